rtc_core: RTL
=============

# rtc_core

Parametrised second-generation time-of-day core for the current-time page: keeps hh:mm:ss in 24-hour form, debounces the four direction buttons internally, supports field-by-field adjustment with full carry/borrow and hold-to-repeat, and adds 12-hour display, a per-second tick and a minute-resolution alarm. Its packed BCD `time_data` output feeds the existing seven-segment display driver. The `clear` input re-zeroes the clock when the machine powers on.

## Interface
- `CLK_HZ`, 100_000_000: clk cycles per second.
- `DEBOUNCE_CYCLES`, 1_000_000: button sampling period in cycles.
- `REPEAT_DELAY`, 50_000_000: hold time in cycles before LEFT/RIGHT auto-repeat starts.
- `REPEAT_PERIOD`, 10_000_000: cycles between auto-repeat steps.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `btn`  in  4  raw buttons: [0]=UP, [1]=LEFT, [2]=RIGHT, [3]=DOWN.
- `clear`  in  1  a rising edge zeroes the time.
- `fmt_12h`  in  1  1 = 12-hour display, 0 = 24-hour display.
- `alarm_en`  in  1  alarm enable.
- `alarm_hr`  in  5  alarm hour, 0–23.
- `alarm_min`  in  6  alarm minute, 0–59.
- `time_data`  out  32  BCD {H1,H0,F,M1,M0,F,S1,S0}; F = 4'hF is the separator.
- `adjust_led`  out  1  high while in ADJUST state.
- `location_led`  out  6  one-hot selected field.
- `pm_led`  out  1  hr ≥ 12.
- `sec_tick`  out  1  one-cycle pulse on each RUN second increment.
- `alarm_pulse`  out  1  one-cycle alarm strobe.

## Operation
- **Reset values.** sec = min = hr = 0; divider = 0; state = RUN; `location_led` = 6'b000001; `time_data` = 32'h00F00F00; every other output = 0.
- **Debounce.** `btn` is sampled every DEBOUNCE_CYCLES into `key_vc`, and the previous sample is held in `key_vp`. A press event fires only when `key_vc & ~key_vp` is exactly one-hot. Events with more than one bit set are ignored.
- **State machine, RUN ↔ ADJUST.** A DOWN event toggles the state.
  - Entering ADJUST holds the divider at 0.
  - Leaving ADJUST restarts the divider from 0.
- **RUN.**
  - The divider counts 0..CLK_HZ-1.
  - At CLK_HZ-1 it wraps, increments the time with full ripple carry (23:59:59 → 00:00:00) and pulses `sec_tick`.
- **ADJUST, field selection.** An UP event rotates `location` left: 000001 (S0) → 000010 (S1) → 000100 (M0) → 001000 (M1) → 010000 (H0) → 100000 (H1) → 000001.
- **ADJUST, RIGHT (+).**
  - Unit fields add 1. At 59 (or 23 for hours) the field wraps to 0 and carries into the next higher unit; the carry ripples through hours.
  - Tens fields add 10 when tens < 5. Otherwise they subtract 50 and carry.
  - H1: +10 saturates at 23; when tens = 2 the result is hr − 20.
- **ADJUST, LEFT (−).** Mirror image of RIGHT with borrow. 00:00:00 −1 s gives 23:59:59.
  - S1/M1 with tens = 0 add 50 and borrow.
  - H1 with tens = 0 gives hr + 20, clamped to 23.
- **Auto-repeat.**
  - LEFT/RIGHT held (debounced level, sole bit set) for REPEAT_DELAY cycles produces a step.
  - Further steps follow every REPEAT_PERIOD cycles.
  - Release, or any other bit becoming set, resets the repeat counter.
- **Clear.** A rising edge of `clear` (previous-cycle register) forces:
  - time = 0 and divider = 0;
  - state = RUN and `location` = 000001.
  - Clear takes priority over a tick or button event in the same cycle.
- **Display.**
  - 24-hour mode: H1/H0 = hr/10, hr%10.
  - 12-hour mode: the displayed hour is 12 for hr ∈ {0, 12}, hr−12 for 13..23, else hr.
  - `pm_led` = (hr ≥ 12) in both modes.
  - Minutes and seconds are plain BCD.
- **Alarm.**
  - `alarm_pulse` fires on a RUN tick whose resulting time equals alarm_hr:alarm_min:00 while `alarm_en` = 1.
  - Changes made in ADJUST never fire the alarm.
  - Out-of-range alarm values never match.

## Timing
- All outputs are registered.
- `time_data`, `pm_led`, `location_led` and `adjust_led` update one cycle after the internal state changes.
- A `fmt_12h` change is reflected one cycle later.
- `sec_tick` and `alarm_pulse` are high for exactly the cycle after the tick edge.
- Button latency from a stable level to the step: at most DEBOUNCE_CYCLES + 2 cycles.
- First RUN tick after reset, clear, or leaving ADJUST: CLK_HZ cycles later.
- Asserting `rst` mid-operation immediately forces all reset values and aborts any repeat.

## Test plan
Parameters for all scenarios: CLK_HZ = 10, DEBOUNCE_CYCLES = 2, REPEAT_DELAY = 20, REPEAT_PERIOD = 5.

1. Reset then 10 cycles → `sec_tick` pulses once and `time_data` = 32'h00F00F01. Preload 23:59:59 via LEFT at S0, then one tick → 32'h00F00F00.
2. DOWN, then RIGHT ×1 at S1 starting from 00:00:55 → 00:01:05. LEFT at H1 from 05:00:00 → 23:00:00 (clamped).
3. ADJUST with RIGHT held 40 cycles at S0 → exactly 1 + 4 repeat steps (±1 debounce-phase step). DOWN+UP pressed together → no state change.
4. `fmt_12h` = 1 at 00:00:00 → H digits "12", `pm_led` = 0. At 13:05:00 → "01", `pm_led` = 1.
5. Alarm 00:01, `alarm_en` = 1, run from 00:00:58 → one `alarm_pulse` after the second tick. Set 00:01:00 in ADJUST → no pulse.
6. `clear` rising edge coincident with a tick and a RIGHT event at 12:34:56 in ADJUST → 00:00:00, RUN, `location_led` = 000001. Then `rst` low mid-repeat → all reset values.

Source files
------------

// File: rtl/rtc_core.sv
// rtc_core: hh:mm:ss time-of-day core with debounced adjust, auto-repeat, 12h display, tick and alarm
module rtc_core #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn,
    input  logic        clear,
    input  logic        fmt_12h,
    input  logic        alarm_en,
    input  logic [4:0]  alarm_hr,
    input  logic [5:0]  alarm_min,
    output logic [31:0] time_data,
    output logic        adjust_led,
    output logic [5:0]  location_led,
    output logic        pm_led,
    output logic        sec_tick,
    output logic        alarm_pulse
);
    localparam int DW = $clog2(CLK_HZ + 1);
    localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_DELAY + 1);

    typedef enum logic {RUN, ADJUST} state_t;

    state_t          state, state_n;
    logic [DW-1:0]   div;
    logic [BW-1:0]   deb_cnt;
    logic [RW-1:0]   rep_cnt;
    logic [3:0]      key_vc, key_vp, edge_k;
    logic            samp_q, clr_q, evt, lvl_rep, rep_step, clear_evt;
    logic            in_adj, tick, adj_step, adj_up;
    logic [5:0]      sec, min, location;
    logic [4:0]      hr, hd;
    logic [16:0]     tick_res, adj_res;

    // One step of the selected field in either direction; unit fields ripple carry/borrow up through hours.
    function automatic logic [16:0] step(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                                         input logic [5:0] loc, input logic up);
        logic [5:0] si, mi, st, mt;
        logic [4:0] hi, ht;
        logic       sc, mc, hc;
        si = loc[0] ? 6'd1 : loc[1] ? 6'd10 : 6'd0;
        sc = up ? s > 6'd59 - si : s < si;
        st = up ? (sc ? s + si - 6'd60 : s + si) : (sc ? s + 6'd60 - si : s - si);
        mi = (loc[2] ? 6'd1 : loc[3] ? 6'd10 : 6'd0) + 6'(sc);
        mc = up ? m > 6'd59 - mi : m < mi;
        mt = up ? (mc ? m + mi - 6'd60 : m + mi) : (mc ? m + 6'd60 - mi : m - mi);
        hi = 5'(loc[4]) + 5'(mc);
        hc = up ? h > 5'd23 - hi : h < hi;
        ht = loc[5] ? (up ? (h >= 5'd20 ? h - 5'd20 : h > 5'd13 ? 5'd23 : h + 5'd10)
                          : (h < 5'd10 ? (h > 5'd3 ? 5'd23 : h + 5'd20) : h - 5'd10))
                    : (up ? (hc ? h + hi - 5'd24 : h + hi) : (hc ? h + 5'd24 - hi : h - hi));
        return {ht, mt, st};
    endfunction

    function automatic logic [7:0] bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] o;
        t = v >= 6'd50 ? 4'd5 : v >= 6'd40 ? 4'd4 : v >= 6'd30 ? 4'd3 : v >= 6'd20 ? 4'd2 : v >= 6'd10 ? 4'd1 : 4'd0;
        o = v - {2'b00, t} * 6'd10;
        return {t, o[3:0]};
    endfunction

    // Button edge/level decode and clear edge detection
    always_comb begin
        edge_k    = key_vc & ~key_vp;
        evt       = samp_q && $onehot(edge_k);
        lvl_rep   = key_vc == 4'b0010 || key_vc == 4'b0100;
        rep_step  = lvl_rep && rep_cnt == RW'(REPEAT_DELAY - 1);
        clear_evt = clear && !clr_q;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= RUN;
        else      state <= state_n;

    // FSM next state: clear forces RUN, a DOWN event toggles
    always_comb state_n = clear_evt ? RUN : (evt && edge_k[3]) ? (state == RUN ? ADJUST : RUN) : state;

    // FSM outputs: adjust flag and the RUN second tick (suppressed by clear)
    always_comb begin
        in_adj = state == ADJUST;
        tick   = state == RUN && div == DW'(CLK_HZ - 1) && !clear_evt;
    end

    // Next-time candidates and displayed hour
    always_comb begin
        adj_step = in_adj && ((evt && (edge_k[1] || edge_k[2])) || rep_step);
        adj_up   = evt ? edge_k[2] : key_vc[2];
        tick_res = step(hr, min, sec, 6'b000001, 1'b1);
        adj_res  = step(hr, min, sec, location, adj_up);
        hd       = !fmt_12h ? hr : (hr == 5'd0 || hr == 5'd12) ? 5'd12 : hr > 5'd12 ? hr - 5'd12 : hr;
    end

    // Debounce sampling and hold-to-repeat counter
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            deb_cnt <= '0;
            samp_q  <= 1'b0;
            key_vc  <= '0;
            key_vp  <= '0;
            rep_cnt <= '0;
            clr_q   <= 1'b0;
        end else begin
            deb_cnt <= deb_cnt == BW'(DEBOUNCE_CYCLES - 1) ? '0 : deb_cnt + 1'b1;
            samp_q  <= deb_cnt == BW'(DEBOUNCE_CYCLES - 1);
            key_vc  <= deb_cnt == BW'(DEBOUNCE_CYCLES - 1) ? btn : key_vc;
            key_vp  <= deb_cnt == BW'(DEBOUNCE_CYCLES - 1) ? key_vc : key_vp;
            rep_cnt <= !lvl_rep ? '0 : rep_step ? RW'(REPEAT_DELAY - REPEAT_PERIOD) : rep_cnt + 1'b1;
            clr_q   <= clear;
        end

    // Divider, time-of-day and field selection; clear beats tick and adjust steps
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            div            <= '0;
            {hr, min, sec} <= '0;
            location       <= 6'b000001;
        end else begin
            div            <= (clear_evt || tick || in_adj || state_n == ADJUST) ? '0 : div + 1'b1;
            {hr, min, sec} <= clear_evt ? 17'd0 : tick ? tick_res : adj_step ? adj_res : {hr, min, sec};
            location       <= clear_evt ? 6'b000001 : (in_adj && evt && edge_k[0]) ? {location[4:0], location[5]} : location;
        end

    // Registered outputs
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            time_data    <= 32'h00F00F00;
            location_led <= 6'b000001;
            adjust_led   <= 1'b0;
            pm_led       <= 1'b0;
            sec_tick     <= 1'b0;
            alarm_pulse  <= 1'b0;
        end else begin
            time_data    <= {bcd({1'b0, hd}), 4'hF, bcd(min), 4'hF, bcd(sec)};
            location_led <= location;
            adjust_led   <= in_adj;
            pm_led       <= hr >= 5'd12;
            sec_tick     <= tick;
            alarm_pulse  <= tick && alarm_en && tick_res == {alarm_hr, alarm_min, 6'd0};
        end
endmodule
